pattern_tx_engine: RTL and testbench
====================================

PATTERN_TX_ENGINE -- requirements
Module: pattern_tx_engine

Interface
REQ-001 SHALL have parameter DATA_BYTES, default 4, meaning pattern length in bytes (frame length L = 8*DATA_BYTES bits; legal 1..16).
REQ-002 SHALL have parameter CNT_W, default 32, meaning width of the frame counter and burst length.
REQ-003 SHALL have parameter MSB_FIRST, default 1, meaning bit order within each byte (1 = bit 7 first); byte 0 is always sent first.
REQ-004 SHALL have port clk, input, 1, meaning the single clock (transmit bit clock, one bit per cycle).
REQ-005 SHALL have port rst, input, 1, meaning reset, asynchronous and active-high.
REQ-006 SHALL have port enable, input, 1, meaning run request.
REQ-007 SHALL have port mode, input, 1, meaning 0 = continuous, 1 = burst; sampled only on the IDLE->SEND transition.
REQ-008 SHALL have port burst_frames, input, CNT_W, meaning frames per burst; sampled with mode.
REQ-009 SHALL have port wr_valid, input, 1, meaning shadow pattern byte write strobe.
REQ-010 SHALL have port wr_addr, input, $clog2(DATA_BYTES) (min 1), meaning shadow byte index.
REQ-011 SHALL have port wr_data, input, 8, meaning shadow byte value.
REQ-012 SHALL have port commit, input, 1, meaning request to copy shadow into active pattern.
REQ-013 SHALL have port tx_bit_data, output, 1, meaning serial data out.
REQ-014 SHALL have port frame_start, output, 1, meaning one-cycle pulse coincident with bit 0 of each frame.
REQ-015 SHALL have port tx_active, output, 1, meaning high while in SEND.
REQ-016 SHALL have port max_tx_flag, output, 1, meaning burst complete.
REQ-017 SHALL have port frame_count, output, CNT_W, meaning completed frames since leaving IDLE, saturating at all-ones.

Function
REQ-018 SHALL implement states IDLE, SEND, DONE; all outputs registered.
REQ-019 IDLE: tx_bit_data=0, tx_active=0; enable=1 -> SEND, first bit on tx_bit_data the cycle after enable is sampled high (latency 1), frame_start=1 that cycle.
REQ-020 SEND: one bit per clk; bit index 0..L-1 wraps to 0; on wrap frame_count increments (saturating).
REQ-021 Burst mode: when the completing frame makes frame_count equal burst_frames -> DONE; no further bits sent.
REQ-022 Burst mode with burst_frames=0 -> DONE directly from IDLE with no bits sent, frame_count=0.
REQ-023 enable deasserted in SEND: current frame completes in full, then IDLE; frame_count retains value until next IDLE->SEND, where it clears to 0.
REQ-024 DONE: max_tx_flag=1, tx_bit_data=0, tx_active=0; enable=0 -> IDLE and max_tx_flag clears next cycle.
REQ-025 wr_valid writes wr_data to shadow[wr_addr] next edge; wr_addr >= DATA_BYTES ignored.
REQ-026 commit sets a pending flag; active pattern loads from shadow in IDLE immediately, or in SEND only at frame boundary (after bit L-1), never mid-frame.
REQ-027 wr_valid and commit same cycle: committed pattern SHALL include that write.
REQ-028 commit during the last bit of a frame SHALL take effect from the next frame.

Reset
REQ-029 rst SHALL force state IDLE, tx_bit_data=0, frame_start=0, tx_active=0, max_tx_flag=0, frame_count=0, pending=0.
REQ-030 rst SHALL load shadow and active bytes to 8'hA5; reset mid-frame SHALL abort the frame immediately.

Structure
REQ-031 State encoding and reset pattern constant (8'hA5) SHALL live in shared package ba1533_tx_pkg.
REQ-032 One sub-module natural: pattern_regs (shadow/active bank with commit-pending logic); sequencing in top.

Verification
REQ-033 Reset, enable=1, mode=0, DATA_BYTES=4, MSB_FIRST=1 -> 10100101 repeated 4x per frame, frame_start every 32 cycles, first bit 1 cycle after enable.
REQ-034 Burst mode, burst_frames=3 -> exactly 96 bits, frame_count=3, max_tx_flag=1 until enable=0, then 0 next cycle.
REQ-035 Continuous mode, write byte0=8'h0F and commit at bit 10 of frame -> current frame unchanged, next frame starts 00001111.
REQ-036 burst_frames=0, mode=1, enable=1 -> no bits, DONE, max_tx_flag=1, frame_count=0.
REQ-037 enable dropped at bit 5 -> bits 5..31 still sent, then IDLE with tx_bit_data=0; rst asserted at bit 12 -> outputs zero immediately.

Source files
------------

// File: rtl/ba1533_tx_pkg.sv
// rtl/ba1533_tx_pkg.sv - shared state encoding, reset pattern and bit-order helper
package ba1533_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } tx_state_e;

  localparam logic [7:0] RESET_PATTERN = 8'hA5;

  // Position of serial step k (0..7) inside a byte; MSB-first walks 7 down to 0.
  function automatic logic [2:0] bit_in_byte(input logic [2:0] k, input logic msb_first);
    return msb_first ? ~k : k;
  endfunction

endpackage

// File: rtl/pattern_tx_engine_if.sv
// rtl/pattern_tx_engine_if.sv - shadow pattern write / commit bus
interface pattern_tx_engine_if #(
  parameter int AW = 2
) ();

  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          commit;

  modport master (output wr_valid, output wr_addr, output wr_data, output commit);
  modport slave  (input  wr_valid, input  wr_addr, input  wr_data, input  commit);

endinterface

// File: rtl/pattern_regs.sv
// rtl/pattern_regs.sv - shadow/active pattern bank with commit-pending logic
module pattern_regs
  import ba1533_tx_pkg::*;
#(
  parameter int DATA_BYTES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  pattern_tx_engine_if.slave      wr,
  input  logic                    load_ok_i,
  output logic [8*DATA_BYTES-1:0] pattern_nxt_o
);

  logic [8*DATA_BYTES-1:0] shadow_q, shadow_d;
  logic [8*DATA_BYTES-1:0] active_q, active_d;
  logic                    pending_q, pending_d;
  logic                    load;

  // Out-of-range addresses simply match no byte lane.
  always_comb begin
    shadow_d = shadow_q;
    for (int i = 0; i < DATA_BYTES; i++) begin
      if (wr.wr_valid && (32'(wr.wr_addr) == i)) begin
        shadow_d[i*8 +: 8] = wr.wr_data;
      end
    end
  end

  // Load sees the same-cycle write and commit, so a commit on the last bit
  // already applies to the frame that starts on this edge.
  assign load      = (pending_q | wr.commit) & load_ok_i;
  assign pending_d = load ? 1'b0 : (pending_q | wr.commit);
  assign active_d  = load ? shadow_d : active_q;

  assign pattern_nxt_o = active_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q  <= {DATA_BYTES{RESET_PATTERN}};
      active_q  <= {DATA_BYTES{RESET_PATTERN}};
      pending_q <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
    end
  end

endmodule

// File: rtl/pattern_tx_engine.sv
// rtl/pattern_tx_engine.sv - serial pattern transmitter with continuous and burst modes
module pattern_tx_engine
  import ba1533_tx_pkg::*;
#(
  parameter int DATA_BYTES = 4,
  parameter int CNT_W      = 32,
  parameter int MSB_FIRST  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             mode,
  input  logic [CNT_W-1:0] burst_frames,
  pattern_tx_engine_if.slave wr,
  output logic             tx_bit_data,
  output logic             frame_start,
  output logic             tx_active,
  output logic             max_tx_flag,
  output logic [CNT_W-1:0] frame_count
);

  localparam int L  = 8 * DATA_BYTES;
  localparam int BW = $clog2(L);

  tx_state_e        state_q;
  logic [BW-1:0]    bit_q;
  logic [CNT_W-1:0] frame_cnt_q, burst_q, frame_cnt_inc;
  logic             mode_q, tx_bit_q, frame_start_q, tx_active_q, max_q;

  logic [L-1:0]     pattern_nxt;
  logic             last_bit, load_ok, start_bit, seq_bit;
  logic [BW-1:0]    next_idx;

  function automatic logic pick(input logic [L-1:0] pat, input logic [BW-1:0] k);
    logic [BW-1:0] pos;
    pos      = k;
    pos[2:0] = bit_in_byte(k[2:0], MSB_FIRST != 0);
    return pat[pos];
  endfunction

  assign last_bit      = (state_q == ST_SEND) && (bit_q == BW'(L - 1));
  assign load_ok       = (state_q == ST_IDLE) || last_bit;
  assign next_idx      = bit_q + 1'b1;
  assign start_bit     = pick(pattern_nxt, '0);
  assign seq_bit       = pick(pattern_nxt, next_idx);
  assign frame_cnt_inc = (&frame_cnt_q) ? frame_cnt_q : frame_cnt_q + 1'b1;

  pattern_regs #(.DATA_BYTES(DATA_BYTES)) u_regs (
    .clk           (clk),
    .rst           (rst),
    .wr            (wr),
    .load_ok_i     (load_ok),
    .pattern_nxt_o (pattern_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      bit_q         <= '0;
      frame_cnt_q   <= '0;
      burst_q       <= '0;
      mode_q        <= 1'b0;
      tx_bit_q      <= 1'b0;
      frame_start_q <= 1'b0;
      tx_active_q   <= 1'b0;
      max_q         <= 1'b0;
    end else begin
      frame_start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          tx_bit_q    <= 1'b0;
          tx_active_q <= 1'b0;
          max_q       <= 1'b0;
          bit_q       <= '0;
          if (enable) begin
            frame_cnt_q <= '0;
            mode_q      <= mode;
            burst_q     <= burst_frames;
            if (mode && (burst_frames == '0)) begin
              state_q <= ST_DONE;
              max_q   <= 1'b1;
            end else begin
              state_q       <= ST_SEND;
              tx_active_q   <= 1'b1;
              tx_bit_q      <= start_bit;
              frame_start_q <= 1'b1;
            end
          end
        end
        ST_SEND: begin
          if (last_bit) begin
            frame_cnt_q <= frame_cnt_inc;
            bit_q       <= '0;
            if (mode_q && (frame_cnt_inc == burst_q)) begin
              state_q     <= ST_DONE;
              tx_bit_q    <= 1'b0;
              tx_active_q <= 1'b0;
              max_q       <= 1'b1;
            end else if (!enable) begin
              state_q     <= ST_IDLE;
              tx_bit_q    <= 1'b0;
              tx_active_q <= 1'b0;
            end else begin
              tx_bit_q      <= start_bit;
              frame_start_q <= 1'b1;
            end
          end else begin
            bit_q    <= next_idx;
            tx_bit_q <= seq_bit;
          end
        end
        ST_DONE: begin
          tx_bit_q    <= 1'b0;
          tx_active_q <= 1'b0;
          if (!enable) begin
            state_q <= ST_IDLE;
            max_q   <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign tx_bit_data = tx_bit_q;
  assign frame_start = frame_start_q;
  assign tx_active   = tx_active_q;
  assign max_tx_flag = max_q;
  assign frame_count = frame_cnt_q;

endmodule

// File: tb/tb_pattern_tx_engine.sv
// tb/tb_pattern_tx_engine.sv - self-checking bench for pattern_tx_engine
module tb_pattern_tx_engine;

  localparam int L = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        mode;
  logic [31:0] burst_frames;
  logic        tx_bit_data, frame_start, tx_active, max_tx_flag;
  logic [31:0] frame_count;

  int checks = 0;
  int errors = 0;

  pattern_tx_engine_if #(.AW(2)) wr_if ();

  pattern_tx_engine #(.DATA_BYTES(4), .CNT_W(32), .MSB_FIRST(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .mode         (mode),
    .burst_frames (burst_frames),
    .wr           (wr_if),
    .tx_bit_data  (tx_bit_data),
    .frame_start  (frame_start),
    .tx_active    (tx_active),
    .max_tx_flag  (max_tx_flag),
    .frame_count  (frame_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks the transmitter as "sending / done / idle" plus a
  // position in the frame, and derives each output bit from the byte array.
  logic [7:0]  m_shadow [4];
  logic [7:0]  m_active [4];
  bit          m_sending, m_done, m_pending, m_fs, m_mode;
  int          m_pos;
  logic [31:0] m_frames, m_burst;

  task automatic m_load();
    for (int b = 0; b < 4; b++) m_active[b] = m_shadow[b];
    m_pending = 1'b0;
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        for (int b = 0; b < 4; b++) begin
          m_shadow[b] = 8'hA5;
          m_active[b] = 8'hA5;
        end
        m_sending = 0; m_done = 0; m_pending = 0; m_fs = 0; m_mode = 0;
        m_pos = 0; m_frames = 0; m_burst = 0;
      end else begin
        m_fs = 0;
        if (wr_if.wr_valid) m_shadow[wr_if.wr_addr] = wr_if.wr_data;
        if (wr_if.commit) m_pending = 1;
        if (m_sending) begin
          if (m_pos == L - 1) begin
            if (m_frames != 32'hFFFF_FFFF) m_frames = m_frames + 1;
            if (m_pending) m_load();
            if (m_mode && m_frames == m_burst) begin
              m_sending = 0; m_done = 1;
            end else if (!enable) begin
              m_sending = 0;
            end else begin
              m_pos = 0; m_fs = 1;
            end
          end else begin
            m_pos++;
          end
        end else if (m_done) begin
          if (!enable) m_done = 0;
        end else begin
          if (m_pending) m_load();
          if (enable) begin
            m_frames = 0; m_mode = mode; m_burst = burst_frames;
            if (mode && burst_frames == 0) m_done = 1;
            else begin m_sending = 1; m_pos = 0; m_fs = 1; end
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("model_tx_bit", tx_bit_data, m_sending ? m_active[m_pos/8][7-(m_pos%8)] : 1'b0);
        chk("model_frame_start", frame_start, m_fs);
        chk("model_tx_active", tx_active, m_sending);
        chk("model_max_flag", max_tx_flag, m_done);
        chk("model_frame_count", frame_count, m_frames);
      end
    end
  end

  // Capture one 32-bit frame (bit 0 in the MSB); at step act_at drive the
  // given write/commit and optionally drop enable.
  task automatic capture(output logic [31:0] bits, output logic [31:0] fs, input int act_at,
                         input logic [1:0] a, input logic [7:0] d, input logic wv,
                         input logic cm, input logic drop);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      wr_if.wr_valid = 1'b0;
      wr_if.commit   = 1'b0;
      bits[31-i] = tx_bit_data;
      fs[31-i]   = frame_start;
      if (i == act_at) begin
        wr_if.wr_valid = wv;
        wr_if.wr_addr  = a;
        wr_if.wr_data  = d;
        wr_if.commit   = cm;
        if (drop) enable = 1'b0;
      end
    end
  endtask

  logic [31:0] f, s;
  int act_cnt, ones_cnt;

  initial begin
    rst = 1'b1; enable = 1'b0; mode = 1'b0; burst_frames = '0;
    wr_if.wr_valid = 1'b0; wr_if.wr_addr = '0; wr_if.wr_data = '0; wr_if.commit = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {tx_bit_data, frame_start, tx_active, max_tx_flag}, 4'b0000);
    chk("reset_count", frame_count, 32'd0);
    rst = 1'b0;

    enable = 1'b1;
    capture(f, s, 10, 2'd0, 8'h0F, 1'b1, 1'b1, 1'b0);
    chk("frame1_bits", f, 32'hA5A5A5A5);
    chk("frame1_start", s, 32'h80000000);
    capture(f, s, 31, 2'd1, 8'h3C, 1'b1, 1'b1, 1'b0);
    chk("frame2_bits", f, 32'h0FA5A5A5);
    chk("frame2_start", s, 32'h80000000);
    capture(f, s, 3, 2'd2, 8'h11, 1'b1, 1'b0, 1'b0);
    chk("frame3_last_bit_commit", f, 32'h0F3CA5A5);
    capture(f, s, 20, 2'd0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("frame4_no_commit_yet", f, 32'h0F3CA5A5);
    capture(f, s, -1, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("frame5_commit_only", f, 32'h0F3C11A5);
    chk("frame5_count", frame_count, 32'd4);

    capture(f, s, 5, 2'd0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("drop_frame_full", f, 32'h0F3C11A5);
    @(negedge clk);
    chk("drop_idle_out", {tx_bit_data, tx_active}, 2'b00);
    chk("drop_count", frame_count, 32'd6);

    enable = 1'b1;
    for (int i = 0; i < 13; i++) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midreset_outputs", {tx_bit_data, frame_start, tx_active, max_tx_flag}, 4'b0000);
    chk("midreset_count", frame_count, 32'd0);
    enable = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    enable = 1'b1;
    capture(f, s, 0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("post_reset_pattern", f, 32'hA5A5A5A5);
    @(negedge clk);
    chk("idle_retains_count", frame_count, 32'd1);

    mode = 1'b1; burst_frames = 32'd3; enable = 1'b1;
    act_cnt = 0; ones_cnt = 0;
    for (int i = 0; i < 110; i++) begin
      @(negedge clk);
      if (i == 0) chk("burst_count_cleared", frame_count, 32'd0);
      act_cnt  += int'(tx_active);
      ones_cnt += int'(tx_bit_data);
    end
    chk("burst_bits_sent", act_cnt, 64'd96);
    chk("burst_ones", ones_cnt, 64'd48);
    chk("burst_done_flag", max_tx_flag, 1'b1);
    chk("burst_done_count", frame_count, 32'd3);
    enable = 1'b0;
    @(negedge clk);
    chk("burst_flag_clear", max_tx_flag, 1'b0);

    burst_frames = 32'd0; enable = 1'b1;
    @(negedge clk);
    chk("zero_burst_flag", {max_tx_flag, tx_active}, 2'b10);
    chk("zero_burst_count", frame_count, 32'd0);
    act_cnt = 0;
    repeat (5) begin
      @(negedge clk);
      act_cnt += int'(tx_active);
    end
    chk("zero_burst_no_bits", act_cnt, 64'd0);
    enable = 1'b0;
    @(negedge clk);
    chk("zero_burst_flag_clear", max_tx_flag, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
